// File: rtl/gray_pkg.sv
// Shared FSM encoding and default sizing for the gray-code step scheduler.
package gray_pkg;

    localparam int GRAY_N  = 8;
    localparam int GRAY_LW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/gray_step_sched.sv
// Burst scheduler that advances a gray-coded counter one step per cycle, with hold, abort and clear.
module gray_step_sched
    import gray_pkg::*;
#(
    parameter int N  = GRAY_N,
    parameter int LW = GRAY_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          hold,
    input  logic          abort,
    input  logic          clr,
    output logic [N-1:0]  gray,
    output logic [N-1:0]  bin,
    output logic          busy,
    output logic          step,
    output logic          wrap,
    output logic          done,
    output logic          aborted,
    output logic          err
);

    localparam logic [N-1:0]  ONE_N  = N'(1);
    localparam logic [LW-1:0] ONE_LW = LW'(1);

    state_t        state, state_nxt;
    logic [N-1:0]  gray_q;
    logic [N-1:0]  bin_cur;
    logic [N-1:0]  bin_inc;
    logic [N-1:0]  gray_inc;
    logic [N-1:0]  gray_delta;
    logic          gray_ok;
    logic [LW-1:0] remaining;
    logic          do_step;
    logic          do_load;
    logic          do_clr;
    logic          wrap_d;
    logic          done_d;
    logic          abort_d;

    // Only the gray value is stored; the binary view is always derived from it.
    gray2bin #(.N(N)) u_gray2bin (
        .gray (gray_q),
        .bin  (bin_cur)
    );

    assign gray = gray_q;
    assign bin  = bin_cur;

    assign bin_inc    = bin_cur + ONE_N;
    assign gray_inc   = bin_inc ^ (bin_inc >> 1);
    assign gray_delta = gray_q ^ gray_inc;
    assign gray_ok    = (|gray_delta) && ~|(gray_delta & (gray_delta - ONE_N));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (hold) begin
                    state_nxt = ST_HOLD;
                end else if (remaining == ONE_LW) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (!hold) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Abort outranks hold, and hold outranks the step, so a step only happens in a clean RUN cycle.
    always_comb begin
        busy    = (state == ST_RUN) || (state == ST_HOLD);
        do_step = (state == ST_RUN) && !abort && !hold;
        do_load = (state == ST_IDLE) && start && (len != '0);
        do_clr  = (state == ST_IDLE) && clr && !start;
        wrap_d  = do_step && (&bin_cur);
        done_d  = (state == ST_DONE);
        abort_d = busy && abort;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_q    <= '0;
            remaining <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            step    <= do_step;
            wrap    <= wrap_d;
            done    <= done_d;
            aborted <= abort_d;
            if (do_clr) begin
                gray_q <= '0;
            end else if (do_step) begin
                gray_q <= gray_inc;
            end
            if (do_load) begin
                remaining <= len;
            end else if (do_step) begin
                remaining <= remaining - ONE_LW;
            end
            if (do_step && !gray_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/gray_step_sched.md
GRAY_STEP_SCHED -- requirements
Module: gray_step_sched

Interface
REQ-001 SHALL have parameter N, default 8, gray/binary counter width (N >= 2).
REQ-002 SHALL have parameter LW, default 16, burst length field width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  burst request; sampled only in IDLE.
REQ-006 SHALL have port len  input  LW  number of steps for the burst; sampled with start.
REQ-007 SHALL have port hold  input  1  suspends stepping while high during a burst.
REQ-008 SHALL have port abort  input  1  terminates the current burst.
REQ-009 SHALL have port clr  input  1  zeroes the counter; honoured only in IDLE.
REQ-010 SHALL have port gray  output  N  current gray-coded count.
REQ-011 SHALL have port bin  output  N  binary equivalent of gray.
REQ-012 SHALL have port busy  output  1  high in RUN and HOLD states.
REQ-013 SHALL have port step  output  1  one-cycle pulse on each counter advance.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse when the counter advances from 2^N-1 to 0.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal burst completion.
REQ-016 SHALL have port aborted  output  1  one-cycle pulse on abort completion.
REQ-017 SHALL have port err  output  1  sticky flag for an illegal gray transition.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, HOLD, DONE.
REQ-019 IDLE: start=1 with len!=0 -> RUN at next edge; latch remaining=len; busy=1 after that edge.
REQ-020 IDLE: start=1 with len==0 -> DONE at next edge; no step is issued.
REQ-021 IDLE: clr=1 (start=0) -> bin=0, gray=0 at next edge; clr with start=1 -> start wins and clr is ignored.
REQ-022 RUN: each edge with hold=0 and abort=0 -> bin+1 modulo 2^N, gray=bin^(bin>>1), remaining-1, step=1.
REQ-023 RUN: the step that takes remaining from 1 to 0 -> DONE.
REQ-024 RUN with hold=1 -> HOLD; no step that cycle. HOLD with hold=0 -> RUN; no step that edge; stepping resumes the following edge.
REQ-025 abort=1 in RUN or HOLD -> IDLE at next edge; aborted=1 for one cycle; no step; abort has priority over hold and over the final step.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 start, len and clr outside IDLE SHALL be ignored; abort and hold in IDLE/DONE SHALL be ignored.
REQ-028 step, wrap, done and aborted SHALL be registered outputs, asserted in the cycle after the edge that caused them.
REQ-029 A burst of len L without hold SHALL give exactly L step pulses on consecutive cycles; done follows the last step by one cycle.
REQ-030 Counter value SHALL persist across bursts; only clr or reset zero it.
REQ-031 err SHALL set when consecutive gray values across a step differ in other than exactly one bit; cleared only by reset.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, gray=0, bin=0, remaining=0, busy=0, step=0, wrap=0, done=0, aborted=0, err=0.
REQ-033 Reset asserted mid-burst SHALL discard the burst without a done or aborted pulse.

Structure
REQ-034 FSM state encoding and the default N/LW constants SHALL live in a shared package, gray_pkg.
REQ-035 Gray-to-binary conversion SHALL be a separate combinational sub-module, gray2bin, used by the err checker.

Verification
REQ-036 reset, then start with len=5 -> five step pulses on consecutive cycles, gray 1,3,2,6,7, then done; busy is high for 5 cycles.
REQ-037 N=8, clr, len=256 -> wrap pulses once, coincident with gray returning to 0x00 from 0x80; done follows the final step.
REQ-038 len=10 with hold high for 3 cycles after the 4th step -> 10 steps total, 4 stall cycles, then done.
REQ-039 len=10 with abort after the 3rd step -> aborted pulse, no done, bin=3, then IDLE.
REQ-040 start with len=0 -> done pulse with no step; start while busy -> ignored, so the burst count is unchanged.
REQ-041 Random start/len/hold/abort for 10k cycles -> err stays 0, and bin always equals gray2bin(gray).
